// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory controller.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      RUN   = 2'd3
   } state_t;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int unsigned LOAD_CNT_W = 16;

endpackage

// File: rtl/imem_sp_ram.sv
// Synchronous single-port instruction RAM, read data registered one cycle after a read.
module imem_sp_ram #(
   parameter int unsigned DEPTH   = 256,
   parameter string       HEXFILE = "",
   parameter int unsigned AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/imem_ctrl.sv
// Sequences program loading and core fetches on a single-port instruction RAM.
// Optional IMEM_CTRL_ALIGN_CHK_EN adds a sticky align_err output for misaligned addresses.
module imem_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH         = 256,
   parameter int unsigned AW            = $clog2(DEPTH),
   parameter logic [31:0] default_instr = NOP_INSTR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_go,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [31:0]           ld_addr,
   input  logic [31:0]           ld_data,
   input  logic                  ld_last,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   output logic                  if_valid,
   output logic [31:0]           if_instr,
   output logic                  cpu_hold,
   output logic [LOAD_CNT_W-1:0] load_cnt,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [AW-1:0]         mem_addr,
   output logic [31:0]           mem_wdata,
`ifdef IMEM_CTRL_ALIGN_CHK_EN
   output logic                  align_err,
`endif
   input  logic [31:0]           mem_rdata
);

   state_t state, state_nxt;
   logic   beat_acc, fetch_acc, fetch_rd;
   logic   fetch_pend, fetch_rd_q;
   logic   beat_ok, fetch_ok;

`ifdef IMEM_CTRL_ALIGN_CHK_EN
   logic beat_mis, fetch_mis;
   assign beat_mis  = (ld_addr[1:0] != 2'b00);
   assign fetch_mis = (if_addr[1:0] != 2'b00);
   assign beat_ok   = (ld_addr[31:2] < 30'(DEPTH)) && !beat_mis;
   assign fetch_ok  = (if_addr[31:2] < 30'(DEPTH)) && !fetch_mis;
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{ld_addr[1:0], if_addr[1:0]};
   assign beat_ok         = (ld_addr[31:2] < 30'(DEPTH));
   assign fetch_ok        = (if_addr[31:2] < 30'(DEPTH));
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, handshake, hold and RAM port drive; everything idles while rst is high.
   always_comb begin
      state_nxt = state;
      ld_ready  = 1'b0;
      cpu_hold  = 1'b1;
      beat_acc  = 1'b0;
      fetch_acc = 1'b0;
      fetch_rd  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               ld_ready = 1'b1;
               if (ld_valid) begin
                  beat_acc  = 1'b1;
                  state_nxt = ld_last ? DRAIN : LOAD;
               end else if (run_go) begin
                  state_nxt = RUN;
               end
            end
            LOAD: begin
               ld_ready = 1'b1;
               if (ld_valid) begin
                  beat_acc = 1'b1;
                  if (ld_last) state_nxt = DRAIN;
               end
            end
            DRAIN: state_nxt = RUN;
            RUN: begin
               cpu_hold = 1'b0;
               if (if_req) begin
                  fetch_acc = 1'b1;
                  if (fetch_ok) begin
                     fetch_rd = 1'b1;
                     mem_en   = 1'b1;
                     mem_addr = if_addr[AW+1:2];
                  end
               end
               if (ld_valid) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
         endcase
         if (beat_acc && beat_ok) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr[AW+1:2];
            mem_wdata = ld_data;
         end
      end
   end

   // Fetch pipeline flags and saturating beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pend <= 1'b0;
         fetch_rd_q <= 1'b0;
         load_cnt   <= '0;
      end else begin
         fetch_pend <= fetch_acc;
         fetch_rd_q <= fetch_rd;
         if (beat_acc) begin
            if (state == IDLE)            load_cnt <= LOAD_CNT_W'(1);
            else if (load_cnt != '1)      load_cnt <= load_cnt + LOAD_CNT_W'(1);
         end else if (state == RUN && state_nxt == LOAD) begin
            load_cnt <= '0;
         end
      end
   end

`ifdef IMEM_CTRL_ALIGN_CHK_EN
   always_ff @(posedge clk) begin
      if (rst)                                align_err <= 1'b0;
      else if ((beat_acc && beat_mis) ||
               (fetch_acc && fetch_mis))      align_err <= 1'b1;
   end
`endif

   assign if_valid = fetch_pend && !rst;
   assign if_instr = (if_valid && fetch_rd_q) ? mem_rdata : default_instr;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed self-checking bench for imem_ctrl with an imem_sp_ram attached to its mem_* ports.
module tb_imem_ctrl;
   import imem_pkg::*;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 8;

   logic        clk = 1'b0;
   logic        rst, run_go, ld_valid, ld_ready, ld_last, if_req, if_valid, cpu_hold;
   logic [31:0] ld_addr, ld_data, if_addr, if_instr, mem_wdata, mem_rdata;
   logic [15:0] load_cnt;
   logic        mem_en, mem_we;
   logic [AW-1:0] mem_addr;
`ifdef IMEM_CTRL_ALIGN_CHK_EN
   logic        align_err;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imem_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .run_go(run_go),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
      .ld_data(ld_data), .ld_last(ld_last),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_instr(if_instr),
      .cpu_hold(cpu_hold), .load_cnt(load_cnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef IMEM_CTRL_ALIGN_CHK_EN
      .align_err(align_err),
`endif
      .mem_rdata(mem_rdata)
   );

   imem_sp_ram #(.DEPTH(DEPTH)) ram (
      .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
      .wdata(mem_wdata), .rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One accepted loader beat, checking the combinational write it produces.
   task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
      ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
      #2;
      check("beat_we", 32'(mem_we), 32'd1);
      check("beat_addr", 32'(mem_addr), 32'(a[AW+1:2]));
      check("beat_wdata", mem_wdata, d);
      step();
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      if_req = 1'b1; if_addr = a;
      step();
      if_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run_go = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      ld_addr = '0; ld_data = '0; if_req = 1'b0; if_addr = '0;
      step();
      #2;
      check("rst_state", 32'(dut.state), 32'(IDLE));
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_instr", if_instr, NOP_INSTR);
      check("rst_load_cnt", 32'(load_cnt), 32'd0);
      check("rst_mem_en", 32'({mem_en, mem_we}), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef IMEM_CTRL_ALIGN_CHK_EN
      check("rst_align_err", 32'(align_err), 32'd0);
`endif
      step();
      rst = 1'b0;
      #2;
      check("idle_ld_ready", 32'(ld_ready), 32'd1);

      // Initial 4-beat image
      beat(32'h0, 32'h0050_0093, 1'b0);
      check("load_state", 32'(dut.state), 32'(LOAD));
      check("load_cnt1", 32'(load_cnt), 32'd1);
      beat(32'h4, 32'h0060_0113, 1'b0);
      beat(32'h8, 32'h0020_81B3, 1'b0);
      beat(32'hC, 32'h0000_006F, 1'b1);
      check("drain_state", 32'(dut.state), 32'(DRAIN));
      check("drain_cnt", 32'(load_cnt), 32'd4);
      check("drain_hold", 32'(cpu_hold), 32'd1);
      check("drain_ready", 32'(ld_ready), 32'd0);
      check("drain_mem_en", 32'(mem_en), 32'd0);
      step();
      check("run_state", 32'(dut.state), 32'(RUN));
      check("run_hold", 32'(cpu_hold), 32'd0);

      // Back-to-back fetches, then out-of-range
      if_req = 1'b1; if_addr = 32'h8;
      #2;
      check("rd_en", 32'({mem_en, mem_we}), 32'b10);
      check("rd_addr", 32'(mem_addr), 32'd2);
      step();
      if_addr = 32'hC;
      check("f8_valid", 32'(if_valid), 32'd1);
      check("f8_instr", if_instr, 32'h0020_81B3);
      step();
      if_addr = 32'h400;
      check("fC_valid", 32'(if_valid), 32'd1);
      check("fC_instr", if_instr, 32'h0000_006F);
      #2;
      check("oor_mem_en", 32'(mem_en), 32'd0);
      step();
      if_req = 1'b0;
      check("oor_valid", 32'(if_valid), 32'd1);
      check("oor_instr", if_instr, NOP_INSTR);
      step();
      check("idle_valid", 32'(if_valid), 32'd0);
      check("idle_instr", if_instr, NOP_INSTR);

      // Load request during RUN with a fetch in flight
      if_req = 1'b1; if_addr = 32'h0;
      ld_valid = 1'b1; ld_addr = 32'h0; ld_data = NOP_INSTR; ld_last = 1'b1;
      #2;
      check("runld_ready", 32'(ld_ready), 32'd0);
      check("runld_we", 32'(mem_we), 32'd0);
      step();
      if_req = 1'b0;
      check("reload_state", 32'(dut.state), 32'(LOAD));
      check("reload_hold", 32'(cpu_hold), 32'd1);
      check("inflight_valid", 32'(if_valid), 32'd1);
      check("inflight_instr", if_instr, 32'h0050_0093);
      check("reload_cnt0", 32'(load_cnt), 32'd0);
      beat(32'h0, NOP_INSTR, 1'b1);
      check("reload_cnt1", 32'(load_cnt), 32'd1);
      step();
      fetch(32'h0);
      check("reload_instr", if_instr, NOP_INSTR);
      check("reload_ram", ram.mem[0], NOP_INSTR);

      // Out-of-range beat is counted but not written
      ld_valid = 1'b1; ld_addr = 32'h400; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
      step();
      #2;
      check("oorbeat_mem_en", 32'(mem_en), 32'd0);
      step();
      ld_valid = 1'b0; ld_last = 1'b0;
      check("oorbeat_cnt", 32'(load_cnt), 32'd1);
      check("oorbeat_state", 32'(dut.state), 32'(DRAIN));
      step();

      // Reset drops a pending fetch result
      fetch(32'h4);
      rst = 1'b1;
      #2;
      check("rstf_valid", 32'(if_valid), 32'd0);
      step();
      rst = 1'b0;

      // Load wins over run_go; reset mid-load keeps RAM contents
      run_go = 1'b1;
      beat(32'h0, 32'h0050_0093, 1'b0);
      run_go = 1'b0;
      check("prio_state", 32'(dut.state), 32'(LOAD));
      beat(32'h4, 32'h0060_0113, 1'b0);
      check("mid_cnt", 32'(load_cnt), 32'd2);
      rst = 1'b1;
      #2;
      check("midrst_ready", 32'(ld_ready), 32'd0);
      check("midrst_hold", 32'(cpu_hold), 32'd1);
      step();
      rst = 1'b0;
      check("midrst_state", 32'(dut.state), 32'(IDLE));
      check("midrst_cnt", 32'(load_cnt), 32'd0);
      run_go = 1'b1;
      step();
      run_go = 1'b0;
      check("go_state", 32'(dut.state), 32'(RUN));
      fetch(32'h4);
      check("retain_instr", if_instr, 32'h0060_0113);

`ifdef IMEM_CTRL_ALIGN_CHK_EN
      if_req = 1'b1; if_addr = 32'h6;
      #2;
      check("mis_mem_en", 32'(mem_en), 32'd0);
      step();
      if_req = 1'b0;
      check("mis_instr", if_instr, NOP_INSTR);
      check("mis_align_err", 32'(align_err), 32'd1);
      step();
      step();
      check("mis_align_held", 32'(align_err), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
